// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4-style accumulator CPU.
// Two registers (A, B) fed by a single src+im adder, an output port register,
// a carry flag with carry-conditional jump, a fetch-valid stall and a HALT
// state that is left with a resume pulse.
module td4_core_param #(
  parameter  int DATA_W  = 4,
  parameter  int ADDR_W  = 4,
  localparam int INSTR_W = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic [DATA_W-1:0]  entrada,
  input  logic               resume,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  out,
  output logic               out_strobe,
  output logic               carry,
  output logic               halted
);

  // Reject parameter sets the datapath cannot support (jump target is a
  // slice of the immediate, so the PC may not be wider than the data path).
  generate
    if (DATA_W < 4 || DATA_W > 16 || ADDR_W < 1 || ADDR_W > DATA_W) begin : g_bad_params
      $error("td4_core_param: illegal DATA_W/ADDR_W combination");
    end
  endgenerate

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_A,
    SRC_B,
    SRC_IN,
    SRC_ZERO
  } src_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic              carry_q;
  logic              out_strobe_q;

  logic [3:0]        op;
  logic [DATA_W-1:0] im;

  src_t              src_sel;
  logic              write_a;
  logic              write_b;
  logic              write_out;
  logic              is_jmp;
  logic              is_jnc;
  logic              is_hlt;

  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum_ext;
  logic              is_alu;
  logic              execute;
  logic              take_jump;
  logic [ADDR_W-1:0] pc_next;
  logic              carry_next;

  assign op = instr[INSTR_W-1:DATA_W];
  assign im = instr[DATA_W-1:0];

  // Opcode decode: which source feeds the adder and where the result goes.
  always_comb begin
    src_sel   = SRC_ZERO;
    write_a   = 1'b0;
    write_b   = 1'b0;
    write_out = 1'b0;
    is_jmp    = 1'b0;
    is_jnc    = 1'b0;
    is_hlt    = 1'b0;
    case (op)
      4'b0000: begin src_sel = SRC_A;    write_a   = 1'b1; end
      4'b0001: begin src_sel = SRC_B;    write_a   = 1'b1; end
      4'b0010: begin src_sel = SRC_IN;   write_a   = 1'b1; end
      4'b0011: begin src_sel = SRC_ZERO; write_a   = 1'b1; end
      4'b0100: begin src_sel = SRC_A;    write_b   = 1'b1; end
      4'b0101: begin src_sel = SRC_B;    write_b   = 1'b1; end
      4'b0110: begin src_sel = SRC_IN;   write_b   = 1'b1; end
      4'b0111: begin src_sel = SRC_ZERO; write_b   = 1'b1; end
      4'b1000: begin src_sel = SRC_A;    write_out = 1'b1; end
      4'b1001: begin src_sel = SRC_B;    write_out = 1'b1; end
      4'b1011: begin src_sel = SRC_ZERO; write_out = 1'b1; end
      4'b1100: is_hlt = 1'b1;
      4'b1110: is_jnc = 1'b1;
      4'b1111: is_jmp = 1'b1;
      default: ;
    endcase
  end

  // Adder source mux; entrada goes straight in so IN sees the live port.
  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:    src = a_q;
      SRC_B:    src = b_q;
      SRC_IN:   src = entrada;
      SRC_ZERO: src = '0;
      default:  src = '0;
    endcase
  end

  assign sum_ext    = {1'b0, src} + {1'b0, im};
  assign is_alu     = write_a | write_b | write_out;
  assign execute    = (state == ST_RUN) && instr_valid;
  assign take_jump  = is_jmp | (is_jnc & ~carry_q);
  assign pc_next    = take_jump ? im[ADDR_W-1:0] : pc_q + ADDR_W'(1);
  assign carry_next = is_alu ? sum_ext[DATA_W] : 1'b0;

  // Architectural state: updated only on an executed instruction.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else if (execute) begin
      pc_q    <= pc_next;
      carry_q <= carry_next;
      if (write_a)   a_q   <= sum_ext[DATA_W-1:0];
      if (write_b)   b_q   <= sum_ext[DATA_W-1:0];
      if (write_out) out_q <= sum_ext[DATA_W-1:0];
    end
  end

  // Output strobe: one cycle after every executed OUT, regardless of value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_strobe_q <= 1'b0;
    end else begin
      out_strobe_q <= execute & write_out;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state: HLT parks the core, resume releases it.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:  if (execute && is_hlt) next_state = ST_HALT;
      ST_HALT: if (resume) next_state = ST_RUN;
      default: next_state = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted = (state == ST_HALT);
  end

  assign address    = pc_q;
  assign out        = out_q;
  assign out_strobe = out_strobe_q;
  assign carry      = carry_q;

endmodule

// File: tb/tb_td4_core_param.sv
// Testbench for td4_core_param: a DATA_W=4 and a DATA_W=8 instance, a
// hand-derived vector table, directed corner sequences and a randomized run
// against a behavioural model of the instruction set.
module tb_td4_core_param;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [7:0]  instr4;
  logic [11:0] instr8;
  logic        instr_valid;
  logic [7:0]  entrada;
  logic        resume;

  logic [3:0]  address4;
  logic [3:0]  out4;
  logic        strobe4;
  logic        carry4;
  logic        halted4;
  logic [3:0]  address8;
  logic [7:0]  out8;
  logic        strobe8;
  logic        carry8;
  logic        halted8;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int pc;
    int a;
    int b;
    int outv;
    int carry;
    int strobe;
    int halted;
  } model_t;

  model_t m[2];

  typedef struct {
    logic [3:0] op;
    logic [3:0] im;
    bit         valid;
    bit         res;
    int         addr;
    int         outv;
    int         strobe;
    int         carry;
    int         halted;
  } vec_t;

  vec_t vecs[16];

  td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk(clk), .n_reset(n_reset), .instr(instr4), .instr_valid(instr_valid),
    .entrada(entrada[3:0]), .resume(resume), .address(address4), .out(out4),
    .out_strobe(strobe4), .carry(carry4), .halted(halted4)
  );

  td4_core_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .n_reset(n_reset), .instr(instr8), .instr_valid(instr_valid),
    .entrada(entrada), .resume(resume), .address(address8), .out(out8),
    .out_strobe(strobe8), .carry(carry8), .halted(halted8)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit later.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] im,
                               input bit valid, input logic [7:0] ent, input bit res);
    instr4      = {op, im[3:0]};
    instr8      = {op, im};
    instr_valid = valid;
    entrada     = ent;
    resume      = res;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m[k].pc = 0; m[k].a = 0; m[k].b = 0; m[k].outv = 0;
      m[k].carry = 0; m[k].strobe = 0; m[k].halted = 0;
    end
  endtask

  task automatic doReset();
    n_reset     = 1'b0;
    instr_valid = 1'b0;
    resume      = 1'b0;
    instr4      = '0;
    instr8      = '0;
    entrada     = '0;
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    modelReset();
  endtask

  // One clock of the instruction-set model for instance k (width 4 or 8).
  task automatic modelStep(input int k, input int op, input int im, input bit valid,
                           input int ent, input bit res);
    int w, mask, src, sum, dest;
    w    = (k == 0) ? 4 : 8;
    mask = (1 << w) - 1;
    im   = im & mask;
    ent  = ent & mask;
    m[k].strobe = 0;
    if (m[k].halted != 0) begin
      if (res) m[k].halted = 0;
      return;
    end
    if (!valid) return;
    dest = -1;
    src  = 0;
    case (op)
      0:  begin dest = 0; src = m[k].a; end
      1:  begin dest = 0; src = m[k].b; end
      2:  begin dest = 0; src = ent;    end
      3:  begin dest = 0; src = 0;      end
      4:  begin dest = 1; src = m[k].a; end
      5:  begin dest = 1; src = m[k].b; end
      6:  begin dest = 1; src = ent;    end
      7:  begin dest = 1; src = 0;      end
      8:  begin dest = 2; src = m[k].a; end
      9:  begin dest = 2; src = m[k].b; end
      11: begin dest = 2; src = 0;      end
      default: ;
    endcase
    if (dest >= 0) begin
      sum = src + im;
      m[k].carry = (sum > mask) ? 1 : 0;
      if (dest == 0) m[k].a = sum & mask;
      if (dest == 1) m[k].b = sum & mask;
      if (dest == 2) begin
        m[k].outv   = sum & mask;
        m[k].strobe = 1;
      end
      m[k].pc = (m[k].pc + 1) % 16;
    end else begin
      if (op == 15)      m[k].pc = im % 16;
      else if (op == 14) m[k].pc = (m[k].carry == 0) ? im % 16 : (m[k].pc + 1) % 16;
      else               m[k].pc = (m[k].pc + 1) % 16;
      if (op == 12) m[k].halted = 1;
      m[k].carry = 0;
    end
  endtask

  task automatic compareModels(input int cyc);
    checkOutput($sformatf("rnd4 addr c%0d", cyc), int'(address4), m[0].pc);
    checkOutput($sformatf("rnd4 out c%0d", cyc), int'(out4), m[0].outv);
    checkOutput($sformatf("rnd4 strobe c%0d", cyc), int'(strobe4), m[0].strobe);
    checkOutput($sformatf("rnd4 carry c%0d", cyc), int'(carry4), m[0].carry);
    checkOutput($sformatf("rnd4 halted c%0d", cyc), int'(halted4), m[0].halted);
    checkOutput($sformatf("rnd8 addr c%0d", cyc), int'(address8), m[1].pc);
    checkOutput($sformatf("rnd8 out c%0d", cyc), int'(out8), m[1].outv);
    checkOutput($sformatf("rnd8 strobe c%0d", cyc), int'(strobe8), m[1].strobe);
    checkOutput($sformatf("rnd8 carry c%0d", cyc), int'(carry8), m[1].carry);
    checkOutput($sformatf("rnd8 halted c%0d", cyc), int'(halted8), m[1].halted);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " addr4"}, int'(address4), 0);
    checkOutput({tag, " out4"}, int'(out4), 0);
    checkOutput({tag, " strobe4"}, int'(strobe4), 0);
    checkOutput({tag, " carry4"}, int'(carry4), 0);
    checkOutput({tag, " halted4"}, int'(halted4), 0);
    checkOutput({tag, " addr8"}, int'(address8), 0);
    checkOutput({tag, " out8"}, int'(out8), 0);
    checkOutput({tag, " carry8"}, int'(carry8), 0);
    checkOutput({tag, " halted8"}, int'(halted8), 0);
  endtask

  initial begin
    // JNC loop, HLT/resume, 3-cycle stall holding carry=1, JMP; DATA_W=4.
    //           op       im     v  r  addr out st c  h
    vecs[0]  = '{4'b0011, 4'd14, 1, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{4'b0000, 4'd1,  1, 0, 2, 0, 0, 0, 0};
    vecs[2]  = '{4'b1110, 4'd1,  1, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{4'b0000, 4'd1,  1, 0, 2, 0, 0, 1, 0};
    vecs[4]  = '{4'b1110, 4'd1,  1, 0, 3, 0, 0, 0, 0};
    vecs[5]  = '{4'b1000, 4'd0,  1, 0, 4, 0, 1, 0, 0};
    vecs[6]  = '{4'b1100, 4'd0,  1, 0, 5, 0, 0, 0, 1};
    vecs[7]  = '{4'b1000, 4'd3,  1, 0, 5, 0, 0, 0, 1};
    vecs[8]  = '{4'b1000, 4'd3,  1, 1, 5, 0, 0, 0, 0};
    vecs[9]  = '{4'b1011, 4'd9,  1, 0, 6, 9, 1, 0, 0};
    vecs[10] = '{4'b0101, 4'd15, 1, 0, 7, 9, 0, 0, 0};
    vecs[11] = '{4'b1001, 4'd1,  1, 0, 8, 0, 1, 1, 0};
    vecs[12] = '{4'b1111, 4'd0,  0, 0, 8, 0, 0, 1, 0};
    vecs[13] = '{4'b1111, 4'd0,  0, 0, 8, 0, 0, 1, 0};
    vecs[14] = '{4'b1111, 4'd0,  0, 0, 8, 0, 0, 1, 0};
    vecs[15] = '{4'b1111, 4'd0,  1, 0, 0, 0, 0, 0, 0};

    doReset();
    checkAllZero("reset");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, {4'h0, vecs[i].im}, vecs[i].valid, 8'h00, vecs[i].res);
      checkOutput($sformatf("vec%0d addr", i), int'(address4), vecs[i].addr);
      checkOutput($sformatf("vec%0d out", i), int'(out4), vecs[i].outv);
      checkOutput($sformatf("vec%0d strobe", i), int'(strobe4), vecs[i].strobe);
      checkOutput($sformatf("vec%0d carry", i), int'(carry4), vecs[i].carry);
      checkOutput($sformatf("vec%0d halted", i), int'(halted4), vecs[i].halted);
    end

    // Counter: ADD A,1 / JMP 0; carry only after the 16th add wraps A.
    doReset();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(4'b0000, 8'h01, 1, 8'h00, 0);
      checkOutput($sformatf("cnt add%0d carry", k), int'(carry4), (k == 16) ? 1 : 0);
      checkOutput($sformatf("cnt add%0d addr", k), int'(address4), 1);
      applyStimulus(4'b1111, 8'h00, 1, 8'h00, 0);
      checkOutput($sformatf("cnt jmp%0d carry", k), int'(carry4), 0);
      checkOutput($sformatf("cnt jmp%0d addr", k), int'(address4), 0);
    end

    // Halt at address 5, hold 10 cycles, resume continues at 6.
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b1010, 8'h00, 1, 8'h00, 0);
    checkOutput("halt pre addr", int'(address4), 5);
    applyStimulus(4'b1100, 8'h00, 1, 8'h00, 0);
    checkOutput("halt enter", int'(halted4), 1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1011, 8'h07, 1, 8'h00, 0);
      checkOutput($sformatf("halt hold%0d addr", k), int'(address4), 6);
      checkOutput($sformatf("halt hold%0d halted", k), int'(halted4), 1);
      checkOutput($sformatf("halt hold%0d out", k), int'(out4), 0);
    end
    applyStimulus(4'b1011, 8'h07, 1, 8'h00, 1);
    checkOutput("resume halted", int'(halted4), 0);
    checkOutput("resume addr", int'(address4), 6);
    applyStimulus(4'b1011, 8'h07, 1, 8'h00, 0);
    checkOutput("post-resume addr", int'(address4), 7);
    checkOutput("post-resume out", int'(out4), 7);
    checkOutput("post-resume strobe", int'(strobe4), 1);

    // Async reset while halted: outputs clear with no clock edge.
    applyStimulus(4'b1100, 8'h00, 1, 8'h00, 0);
    checkOutput("rehalt", int'(halted4), 1);
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("areset halt addr", int'(address4), 0);
    checkOutput("areset halt out", int'(out4), 0);
    checkOutput("areset halt halted", int'(halted4), 0);
    checkOutput("areset halt carry", int'(carry4), 0);
    @(negedge clk);
    n_reset = 1'b1;
    applyStimulus(4'b1011, 8'h05, 1, 8'h00, 0);
    checkOutput("first after reset addr", int'(address4), 1);
    checkOutput("first after reset out", int'(out4), 5);

    // DATA_W=8: IN B with entrada 0xF0 + 0x20, JMP 0x3A, PC wrap 15 -> 0.
    doReset();
    applyStimulus(4'b0110, 8'h20, 1, 8'hF0, 0);
    checkOutput("w8 inb carry", int'(carry8), 1);
    checkOutput("w8 inb addr", int'(address8), 1);
    applyStimulus(4'b1001, 8'h00, 1, 8'h00, 0);
    checkOutput("w8 outb out", int'(out8), 8'h10);
    checkOutput("w8 outb strobe", int'(strobe8), 1);
    checkOutput("w8 outb carry", int'(carry8), 0);
    applyStimulus(4'b1111, 8'h3A, 1, 8'h00, 0);
    checkOutput("w8 jmp addr", int'(address8), 8'h0A);
    for (int k = 11; k <= 16; k++) begin
      applyStimulus(4'b1101, 8'hFF, 1, 8'h00, 0);
      checkOutput($sformatf("w8 pc inc to %0d", k % 16), int'(address8), k % 16);
    end

    // Randomized run against the model on both widths.
    doReset();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] op;
      logic [7:0] im;
      logic [7:0] ent;
      bit         valid;
      bit         res;
      op    = 4'($urandom_range(0, 15));
      im    = 8'($urandom_range(0, 255));
      ent   = 8'($urandom_range(0, 255));
      valid = ($urandom_range(0, 7) != 0);
      res   = ($urandom_range(0, 5) == 0);
      applyStimulus(op, im, valid, ent, res);
      modelStep(0, int'(op), int'(im), valid, int'(ent), res);
      modelStep(1, int'(op), int'(im), valid, int'(ent), res);
      compareModels(c);
    end

    // Async reset mid-program.
    #2;
    n_reset = 1'b0;
    #1;
    checkAllZero("areset run");
    @(negedge clk);
    n_reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/td4_core_param.md
# td4_core_param

Parametrised successor of the 4-bit TD4-style accumulator CPU: same two-register (A, B) immediate-add datapath, output port and carry-conditional jump, generalised to DATA_W-bit data and ADDR_W-bit program address. Adds:

- a fetch handshake (`instr_valid`) so the core stalls on slow program memory;
- a fully decoded opcode map with OUT A, HLT and NOP;
- a halt state with resume;
- a one-cycle output strobe.

It sits between the external program ROM (driven from `address`) and the board I/O (switch inputs, display outputs).

## Interface
- DATA_W, 4: width of A, B, OUT, input port and immediate; legal 4..16.
- ADDR_W, 4: program counter width; must satisfy ADDR_W <= DATA_W; checked at elaboration.
- INSTR_W, 4+DATA_W: derived, not overridable; instr = {op[3:0], im[DATA_W-1:0]}.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  instruction fetched from `address`.
- instr_valid  in  1  instr is valid this cycle; low = stall.
- entrada  in  DATA_W  input port, sampled combinationally by IN instructions.
- resume  in  1  leaves HALT when high for one cycle.
- address  out  ADDR_W  program counter.
- out  out  DATA_W  output port register.
- out_strobe  out  1  one-cycle pulse when `out` was written.
- carry  out  1  carry flag register.
- halted  out  1  high while in HALT.

## Operation
- Reset: PC, A, B, OUT and carry = 0; out_strobe = 0; halted = 0; state = RUN.
- Adder: {c, sum} = src + im, DATA_W+1 bits.
  - src is selected by opcode from A, B, entrada or 0.
  - sum wraps modulo 2^DATA_W.
- Opcode map, one bullet per opcode (dest <= src+im):
  - 0000 ADD A,im: A <= A+im
  - 0001 MOV A,B: A <= B+im
  - 0010 IN A: A <= entrada+im
  - 0011 MOV A,im: A <= 0+im
  - 0100 MOV B,A: B <= A+im
  - 0101 ADD B,im: B <= B+im
  - 0110 IN B: B <= entrada+im
  - 0111 MOV B,im: B <= 0+im
  - 1000 OUT A: OUT <= A+im
  - 1001 OUT B: OUT <= B+im
  - 1011 OUT im: OUT <= 0+im
  - 1110 JNC im: PC <= im[ADDR_W-1:0] if carry==0, else PC+1
  - 1111 JMP im: PC <= im[ADDR_W-1:0]
  - 1100 HLT: PC <= PC+1, enter HALT
  - 1010, 1101 NOP: PC <= PC+1
- Carry:
  - Every executed instruction writes carry.
  - ADD/MOV/IN/OUT write the adder carry-out c.
  - JMP, JNC, NOP and HLT write 0.
  - JNC tests the carry value from before this instruction executes.
- Every executed non-jump instruction increments PC, modulo 2^ADDR_W (the PC after the maximum address is 0).
- State machine, two states:
  - RUN: executes instr when instr_valid=1. When instr_valid=0, nothing changes (PC, A, B, OUT, carry held) and out_strobe = 0.
  - RUN -> HALT: on an executed HLT.
  - HALT: ignores instr and instr_valid; all state held; halted = 1.
  - HALT -> RUN: on resume=1. Execution continues at the held PC, which already points past the HLT.
  - resume in RUN has no effect.
- out_strobe = 1 for exactly the cycle after any executed OUT, even if the value is unchanged.

## Timing
- One instruction per cycle while instr_valid=1; no pipeline.
- Results are visible on `address`, `out` and `carry` on the clock edge that executes the instruction.
- instr and entrada are combinational into the datapath. `address` is a register, so the ROM has a full cycle to present instr.
- HLT: halted rises on the edge executing HLT. After resume is sampled high, halted is 0 the next cycle, and that cycle may execute.
- Reset mid-operation (any state, including HALT or stall) clears everything asynchronously. The first instruction executes at PC 0 on the first edge after n_reset deasserts with instr_valid=1.
- out_strobe is registered; it is not asserted during reset.

## Test plan
- Counter, DATA_W=4: program ADD A,1 / JMP 0, instr_valid=1. A counts 1,2,...,15,0; carry = 1 only in the cycle after the 15->0 wrap.
- JNC loop: MOV A,14 then ADD A,1 / JNC 1, with OUT A after the loop.
  - Branch taken once (A=15, carry 0), falls through when A wraps to 0 with carry 1.
  - OUT A gives out = 0 and out_strobe pulses once.
- Stall: hold instr_valid=0 for 3 cycles mid-program. PC, A, B, OUT and carry are unchanged; out_strobe = 0; execution resumes identically afterwards.
- Halt/resume: HLT at address 5. halted = 1, address holds 6 for 10 cycles; pulse resume; the next executed address is 6.
- Width/wrap, DATA_W=8, ADDR_W=4: IN B with entrada=0xF0, im=0x20 gives B = 0x10 and carry = 1. A JMP with im=0x3A loads PC = 0xA; PC increments 15 -> 0.
- Async reset asserted mid-program and during HALT: all outputs 0 immediately, with no clock edge required.
